// File: rtl/seq_mul_unit_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM encoding and ALU op code.
package seq_mul_unit_pkg;

  localparam int MUL_STATE_WIDTH = 2;
  localparam logic [1:0] ALUOP_MUL = 2'b11;

  typedef enum logic [MUL_STATE_WIDTH-1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_SIGN = 2'd2,
    MUL_DONE = 2'd3
  } mul_state_e;

  function automatic int cntWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_mul_unit_mul_step.sv
// One shift-add step: adds the multiplicand times a BITS_PER_CYCLE-wide multiplier digit
// to the running accumulator.
module mul_step #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [2*WIDTH-1:0]        acc_i,
  input  logic [2*WIDTH-1:0]        mcand_i,
  input  logic [BITS_PER_CYCLE-1:0] digit_i,
  output logic [2*WIDTH-1:0]        acc_o
);

  // mcand_i is already aligned to the digit's weight, so only the in-digit shift is applied here
  always_comb begin
    acc_o = acc_i;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      if (digit_i[j]) begin
        acc_o = acc_o + (mcand_i << j);
      end
    end
  end

endmodule

// File: rtl/seq_mul_unit.sv
// Multi-cycle shift-add multiplier: magnitudes are multiplied unsigned over N RUN cycles,
// then the sign is applied in a single SIGN cycle before the result registers load.
module seq_mul_unit
  import seq_mul_unit_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_lo_o,
  output logic [WIDTH-1:0] result_hi_o
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = cntWidth(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  mul_state_e         state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_q, neg_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   hi_q, hi_d;

  logic [WIDTH-1:0]   aMag, bMag;
  logic [2*WIDTH-1:0] stepAcc;
  logic [2*WIDTH-1:0] product;

  // The most-negative operand negates to itself, which read unsigned is exactly 2^(WIDTH-1)
  assign aMag = (signed_i && a_i[WIDTH-1]) ? (~a_i + WIDTH'(1)) : a_i;
  assign bMag = (signed_i && b_i[WIDTH-1]) ? (~b_i + WIDTH'(1)) : b_i;
  assign product = neg_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;

  mul_step #(
    .WIDTH         (WIDTH),
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_step (
    .acc_i  (acc_q),
    .mcand_i(mcand_q),
    .digit_i(mplier_q[BITS_PER_CYCLE-1:0]),
    .acc_o  (stepAcc)
  );

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    case (state_q)
      MUL_IDLE, MUL_DONE: begin
        if (start_i) begin
          state_d  = MUL_RUN;
          mcand_d  = {{WIDTH{1'b0}}, aMag};
          mplier_d = bMag;
          neg_d    = signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = CNT_LAST;
        end else begin
          state_d = MUL_IDLE;
        end
      end
      MUL_RUN: begin
        acc_d    = stepAcc;
        mcand_d  = mcand_q << BITS_PER_CYCLE;
        mplier_d = mplier_q >> BITS_PER_CYCLE;
        if (cnt_q == '0) begin
          state_d = MUL_SIGN;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      MUL_SIGN: begin
        lo_d    = product[WIDTH-1:0];
        hi_d    = product[2*WIDTH-1:WIDTH];
        state_d = MUL_DONE;
      end
      default: state_d = MUL_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= MUL_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
    end
  end

  assign busy_o      = (state_q == MUL_RUN) || (state_q == MUL_SIGN);
  assign done_o      = (state_q == MUL_DONE);
  assign result_lo_o = lo_q;
  assign result_hi_o = hi_q;

endmodule

// File: tb/tb_seq_mul_unit.sv
// Directed plus randomized checks of seq_mul_unit against a plain-arithmetic product model,
// using one bit-serial instance and one 4-bits-per-cycle instance.
module tb_seq_mul_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start1, sgn1, start4, sgn4;
  logic [31:0] a1, b1, a4, b4;
  logic        busy1, done1, busy4, done4;
  logic [31:0] lo1, hi1, lo4, hi4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_mul_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst(rst), .start_i(start1), .signed_i(sgn1), .a_i(a1), .b_i(b1),
    .busy_o(busy1), .done_o(done1), .result_lo_o(lo1), .result_hi_o(hi1)
  );

  seq_mul_unit #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .start_i(start4), .signed_i(sgn4), .a_i(a4), .b_i(b4),
    .busy_o(busy4), .done_o(done4), .result_lo_o(lo4), .result_hi_o(hi4)
  );

  // Sign-extend (or zero-extend) both operands to 64 bits; the low 64 bits of the product are exact
  function automatic logic [63:0] refProduct(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb;
    ea = sgn ? {{32{a[31]}}, a} : {32'b0, a};
    eb = sgn ? {{32{b[31]}}, b} : {32'b0, b};
    return ea * eb;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit w4, input logic st, input logic sg, input logic [31:0] a, input logic [31:0] b);
    if (w4) begin
      start4 = st; sgn4 = sg; a4 = a; b4 = b;
    end else begin
      start1 = st; sgn1 = sg; a1 = a; b1 = b;
    end
  endtask

  // One-cycle start pulse; operands are scrambled right after acceptance
  task automatic applyStimulus(input bit w4, input logic sg, input logic [31:0] a, input logic [31:0] b,
                               input string tag);
    int n, c, busyCnt;
    logic [63:0] exp;
    n   = w4 ? 8 : 32;
    exp = refProduct(sg, a, b);
    @(negedge clk);
    drive(w4, 1'b1, sg, a, b);
    @(posedge clk);
    @(negedge clk);
    drive(w4, 1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom);
    c = 1;
    busyCnt = 0;
    while (c < 200) begin
      if (w4 ? done4 : done1) break;
      if (w4 ? busy4 : busy1) busyCnt++;
      @(negedge clk);
      c++;
    end
    checkOutput({tag, " latency"}, 64'(c), 64'(n + 2));
    checkOutput({tag, " busy_cycles"}, 64'(busyCnt), 64'(n + 1));
    checkOutput({tag, " product"}, w4 ? {hi4, lo4} : {hi1, lo1}, exp);
    @(negedge clk);
    checkOutput({tag, " done_pulse_end"}, 64'(w4 ? done4 : done1), 64'd0);
    checkOutput({tag, " product_held"}, w4 ? {hi4, lo4} : {hi1, lo1}, exp);
  endtask

  initial begin
    logic        s1, s2;
    logic [31:0] x1, y1, x2, y2;
    int          c, doneSeen;

    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    checkOutput("reset busy", 64'(busy1), 64'd0);
    checkOutput("reset done", 64'(done1), 64'd0);
    checkOutput("reset result", {hi1, lo1}, 64'd0);
    checkOutput("reset result w4", {hi4, lo4}, 64'd0);
    rst = 1'b1;
    $display("[TB] reset released");

    applyStimulus(1'b0, 1'b0, 32'd7, 32'd6, "u7x6");
    checkOutput("u7x6 lo const", 64'(lo1), 64'h2A);
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5, "s-3x5");
    checkOutput("s-3x5 const", {hi1, lo1}, 64'hFFFF_FFFF_FFFF_FFF1);
    applyStimulus(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "sminx-1");
    checkOutput("sminx-1 const", {hi1, lo1}, 64'h0000_0000_8000_0000);
    applyStimulus(1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2, "umaxx2");
    checkOutput("umaxx2 const", {hi1, lo1}, 64'h0000_0001_FFFF_FFFE);
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFF, 32'd2, "smaxx2");
    checkOutput("smaxx2 const", {hi1, lo1}, 64'hFFFF_FFFF_FFFF_FFFE);
    applyStimulus(1'b0, 1'b1, 32'h0, 32'h8000_0000, "zero");
    applyStimulus(1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, "sminxmin");

    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom, "rand1");
    end

    // start_i held high: operands changed mid-RUN must be ignored, then taken in the DONE cycle
    s1 = 1'($urandom_range(0, 1)); x1 = $urandom; y1 = $urandom;
    s2 = 1'($urandom_range(0, 1)); x2 = $urandom; y2 = $urandom;
    @(negedge clk);
    drive(1'b0, 1'b1, s1, x1, y1);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b1, s2, x2, y2);
    c = 1;
    while (c < 200 && !done1) begin
      @(negedge clk);
      c++;
    end
    checkOutput("b2b first latency", 64'(c), 64'd34);
    checkOutput("b2b first product", {hi1, lo1}, refProduct(s1, x1, y1));
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (c < 200 && !done1);
    drive(1'b0, 1'b0, 1'b0, $urandom, $urandom);
    checkOutput("b2b done spacing", 64'(c), 64'd34);
    checkOutput("b2b second product", {hi1, lo1}, refProduct(s2, x2, y2));
    @(negedge clk);
    checkOutput("b2b idle after", 64'({busy1, done1}), 64'd0);

    // Asynchronous reset in the middle of RUN
    applyStimulus(1'b0, 1'b0, 32'h0000_1234, 32'h0000_5678, "pre_reset");
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, $urandom, $urandom);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (9) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("midreset busy", 64'(busy1), 64'd0);
    checkOutput("midreset done", 64'(done1), 64'd0);
    checkOutput("midreset result", {hi1, lo1}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    doneSeen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done1 || busy1) doneSeen++;
    end
    checkOutput("midreset no activity", 64'(doneSeen), 64'd0);
    applyStimulus(1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom, "post_reset");

    applyStimulus(1'b1, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, "w4 dir");
    checkOutput("w4 dir const", {hi4, lo4}, 64'h0B00_EA4E_242D_2080);
    applyStimulus(1'b1, 1'b1, 32'h8000_0000, 32'h7FFF_FFFF, "w4 smin");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom, "rand4");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
